// File: rtl/exec_sched_pkg.sv
// exec_sched_pkg
//   Shared types and constants for the action-execution scheduler.
//   Contents:
//     ADDR_W              width of primitive start / argument base addresses
//     SLOT_W              width of an executor slot index (up to 8 slots)
//     ex_sched_state_e    per-slot state encoding (IDLE/RUN/CPL/REL)
//     next_slot()         round-robin successor of a slot index
package exec_sched_pkg;

  localparam int ADDR_W = 32;
  localparam int SLOT_W = 3;

  typedef enum logic [1:0] {
    EX_SCHED_IDLE = 2'd0,
    EX_SCHED_RUN  = 2'd1,
    EX_SCHED_CPL  = 2'd2,
    EX_SCHED_REL  = 2'd3
  } ex_sched_state_e;

  // Slot after 'cur', wrapping to 0 at 'num'.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] cur,
                                                  input int unsigned       num);
    logic [SLOT_W:0] nxt;
    nxt = {1'b0, cur} + 4'd1;
    return (nxt >= 4'(num)) ? '0 : nxt[SLOT_W-1:0];
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// sched_fifo
//   Request buffer for exec_sched. Circular buffer with power-of-2 depth;
//   the head entry is read straight out of the storage registers.
//   Ports:
//     clk, rst          clock, synchronous active-high reset (empties the FIFO)
//     push, push_data   write request and data
//     pop               remove head entry (ignored when empty)
//     head_data         current head entry
//     full, empty       status, derived from the registered count
//     count             number of stored entries
//   A push while full is taken only when a pop happens in the same cycle.
module sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem[rd_ptr];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/exec_sched.sv
// exec_sched
//   Dispatches action-execution requests (start address, argument base, tag)
//   from a request FIFO to NUM_EXEC executor slots, round-robin over free
//   slots, and runs each executor's start/done handshake. One completion is
//   reported per finished action.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     req_valid_i / req_ready_o   request handshake (ready = FIFO not full)
//     req_start_addr_i, req_args_i, req_tag_i   request payload
//     exe_start_o[k]              start level to executor k
//     exe_start_addr_o, exe_args_o  per-slot address/args, slot k = [32k+31:32k]
//     exe_done_i[k]               done level from executor k (may be sticky)
//     cpl_valid_o, cpl_tag_o, cpl_slot_o   one-cycle completion report
//     busy_o                      FIFO non-empty or any slot not idle
//   Optional build macro EXEC_SCHED_STATS_EN adds stat_disp_o, stat_cpl_o and
//   stat_stall_o (dispatches, completions, cycles with work queued but no free
//   slot), all wrapping 32-bit counters cleared by rst.
//
//   Slot states:
//     state | meaning
//     IDLE  | free, may be dispatched to
//     RUN   | start high, waiting for done (done ignored in the first cycle)
//     CPL   | done seen, start still high, waiting for the completion port
//     REL   | completion reported, start low, counting down the release time
module exec_sched
  import exec_sched_pkg::*;
#(
  parameter int NUM_EXEC       = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_W          = 8,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [ADDR_W-1:0]          req_start_addr_i,
  input  logic [ADDR_W-1:0]          req_args_i,
  input  logic [TAG_W-1:0]           req_tag_i,
  output logic [NUM_EXEC-1:0]        exe_start_o,
  output logic [NUM_EXEC*ADDR_W-1:0] exe_start_addr_o,
  output logic [NUM_EXEC*ADDR_W-1:0] exe_args_o,
  input  logic [NUM_EXEC-1:0]        exe_done_i,
  output logic                       cpl_valid_o,
  output logic [TAG_W-1:0]           cpl_tag_o,
  output logic [SLOT_W-1:0]          cpl_slot_o,
  output logic                       busy_o
`ifdef EXEC_SCHED_STATS_EN
  ,
  output logic [31:0]                stat_disp_o,
  output logic [31:0]                stat_cpl_o,
  output logic [31:0]                stat_stall_o
`endif
);

  localparam int ENTRY_W = TAG_W + 2*ADDR_W;
  localparam int CNT_W   = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CNT_W-1:0] REL_INIT = CNT_W'(RELEASE_CYCLES);

  // Request FIFO, entry = {tag, args, addr}
  logic                        fifo_push;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [ENTRY_W-1:0]          fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [ADDR_W-1:0]           head_addr;
  logic [ADDR_W-1:0]           head_args;
  logic [TAG_W-1:0]            head_tag;

  // Slot state
  ex_sched_state_e   slot_state_q [NUM_EXEC];
  logic [CNT_W-1:0]  rel_cnt_q    [NUM_EXEC];
  logic [TAG_W-1:0]  slot_tag_q   [NUM_EXEC];
  logic [NUM_EXEC-1:0] first_run_q;
  logic [NUM_EXEC-1:0] slot_idle;
  logic [SLOT_W-1:0]   rr_q;

  // Dispatch / completion selection
  logic [7:0]        idle_pad;
  logic [SLOT_W:0]   cand;
  logic              disp_valid;
  logic [SLOT_W-1:0] disp_slot;
  logic              cpl_sel_valid;
  logic [SLOT_W-1:0] cpl_sel_slot;

  assign fifo_push   = req_valid_i & ~fifo_full;
  assign req_ready_o = ~fifo_full;

  sched_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({req_tag_i, req_args_i, req_start_addr_i}),
    .pop       (disp_valid),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_addr = fifo_head[ADDR_W-1:0];
  assign head_args = fifo_head[2*ADDR_W-1:ADDR_W];
  assign head_tag  = fifo_head[ENTRY_W-1:2*ADDR_W];

  always_comb begin
    slot_idle = '0;
    for (int k = 0; k < NUM_EXEC; k++) begin
      slot_idle[k] = (slot_state_q[k] == EX_SCHED_IDLE);
    end
  end

  assign busy_o = (fifo_count != '0) | ~(&slot_idle);

  // Round-robin: first idle slot at or after rr_q, modulo NUM_EXEC.
  // The idle vector is padded to 8 bits so a 3-bit slot index is always legal.
  always_comb begin
    disp_valid = 1'b0;
    disp_slot  = '0;
    cand       = '0;
    idle_pad   = '0;
    idle_pad[NUM_EXEC-1:0] = slot_idle;
    if (!fifo_empty) begin
      for (int i = 0; i < NUM_EXEC; i++) begin
        cand = {1'b0, rr_q} + 4'(i);
        if (cand >= 4'(NUM_EXEC)) cand = cand - 4'(NUM_EXEC);
        if (!disp_valid && idle_pad[cand[SLOT_W-1:0]]) begin
          disp_valid = 1'b1;
          disp_slot  = cand[SLOT_W-1:0];
        end
      end
    end
  end

  // Lowest-index CPL slot gets the completion port.
  always_comb begin
    cpl_sel_valid = 1'b0;
    cpl_sel_slot  = '0;
    for (int k = NUM_EXEC - 1; k >= 0; k--) begin
      if (slot_state_q[k] == EX_SCHED_CPL) begin
        cpl_sel_valid = 1'b1;
        cpl_sel_slot  = SLOT_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q             <= '0;
      cpl_valid_o      <= 1'b0;
      cpl_tag_o        <= '0;
      cpl_slot_o       <= '0;
      exe_start_o      <= '0;
      exe_start_addr_o <= '0;
      exe_args_o       <= '0;
      first_run_q      <= '0;
      for (int k = 0; k < NUM_EXEC; k++) begin
        slot_state_q[k] <= EX_SCHED_IDLE;
        rel_cnt_q[k]    <= '0;
        slot_tag_q[k]   <= '0;
      end
    end else begin
      cpl_valid_o <= 1'b0;
      if (disp_valid) rr_q <= next_slot(disp_slot, NUM_EXEC);
      if (cpl_sel_valid) begin
        cpl_valid_o <= 1'b1;
        cpl_slot_o  <= cpl_sel_slot;
      end

      for (int k = 0; k < NUM_EXEC; k++) begin
        case (slot_state_q[k])
          EX_SCHED_IDLE: begin
            if (disp_valid && disp_slot == SLOT_W'(k)) begin
              slot_state_q[k]                   <= EX_SCHED_RUN;
              exe_start_o[k]                    <= 1'b1;
              first_run_q[k]                    <= 1'b1;
              slot_tag_q[k]                     <= head_tag;
              exe_start_addr_o[k*ADDR_W +: ADDR_W] <= head_addr;
              exe_args_o[k*ADDR_W +: ADDR_W]       <= head_args;
            end
          end
          EX_SCHED_RUN: begin
            // A done level left over from the previous action is still
            // visible in the cycle start rises, so that cycle is skipped.
            if (first_run_q[k]) begin
              first_run_q[k] <= 1'b0;
            end else if (exe_done_i[k]) begin
              slot_state_q[k] <= EX_SCHED_CPL;
            end
          end
          EX_SCHED_CPL: begin
            if (cpl_sel_valid && cpl_sel_slot == SLOT_W'(k)) begin
              slot_state_q[k] <= EX_SCHED_REL;
              exe_start_o[k]  <= 1'b0;
              rel_cnt_q[k]    <= REL_INIT;
              cpl_tag_o       <= slot_tag_q[k];
            end
          end
          EX_SCHED_REL: begin
            rel_cnt_q[k] <= rel_cnt_q[k] - CNT_W'(1);
            if (rel_cnt_q[k] == CNT_W'(1)) slot_state_q[k] <= EX_SCHED_IDLE;
          end
          default: slot_state_q[k] <= EX_SCHED_IDLE;
        endcase
      end
    end
  end

`ifdef EXEC_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_disp_o  <= '0;
      stat_cpl_o   <= '0;
      stat_stall_o <= '0;
    end else begin
      if (disp_valid)    stat_disp_o <= stat_disp_o + 32'd1;
      if (cpl_sel_valid) stat_cpl_o  <= stat_cpl_o + 32'd1;
      if (!fifo_empty && slot_idle == '0) stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_sched.sv
// tb_exec_sched
//   Directed bench for exec_sched (NUM_EXEC=2, FIFO_DEPTH=4, TAG_W=8,
//   RELEASE_CYCLES=2). Inputs change and outputs are sampled 1 time unit
//   after the rising edge; expected values are worked out by hand per cycle.
module tb_exec_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_args;
  logic [7:0]  req_tag;
  logic [1:0]  exe_start;
  logic [63:0] exe_addr;
  logic [63:0] exe_args;
  logic [1:0]  exe_done;
  logic        cpl_valid;
  logic [7:0]  cpl_tag;
  logic [2:0]  cpl_slot;
  logic        busy;
`ifdef EXEC_SCHED_STATS_EN
  logic [31:0] stat_disp;
  logic [31:0] stat_cpl;
  logic [31:0] stat_stall;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] cpl_log [$];

  always #5 clk = ~clk;

  exec_sched #(
    .NUM_EXEC       (2),
    .FIFO_DEPTH     (4),
    .TAG_W          (8),
    .RELEASE_CYCLES (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_start_addr_i (req_addr),
    .req_args_i       (req_args),
    .req_tag_i        (req_tag),
    .exe_start_o      (exe_start),
    .exe_start_addr_o (exe_addr),
    .exe_args_o       (exe_args),
    .exe_done_i       (exe_done),
    .cpl_valid_o      (cpl_valid),
    .cpl_tag_o        (cpl_tag),
    .cpl_slot_o       (cpl_slot),
    .busy_o           (busy)
`ifdef EXEC_SCHED_STATS_EN
    ,
    .stat_disp_o      (stat_disp),
    .stat_cpl_o       (stat_cpl),
    .stat_stall_o     (stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cpl_valid === 1'b1) cpl_log.push_back(cpl_tag);
  endtask

  task automatic drive_req(input logic [7:0] tag);
    req_valid = 1'b1;
    req_tag   = tag;
    req_addr  = 32'h1000 + {24'h0, tag};
    req_args  = 32'h2000 + {24'h0, tag};
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    exe_done  = 2'b00;
    step();
    step();
    rst = 1'b0;
    cpl_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int cnt [7];
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_args  = '0;
    req_tag   = '0;
    exe_done  = 2'b00;

    // ---- 1: single request, reset values, latency, release ----
    do_reset();
    chk("rst_ready", req_ready, 1);
    chk("rst_start", exe_start, 0);
    chk("rst_cpl",   cpl_valid, 0);
    chk("rst_busy",  busy,      0);
    chk("rst_addr",  exe_addr,  0);
    req_valid = 1'b1; req_addr = 32'h100; req_args = 32'h40; req_tag = 8'h5A;
    step();                                  // t+1
    req_valid = 1'b0;
    chk("t1_start_t1", exe_start, 2'b00);
    chk("t1_busy_t1",  busy, 1);
    step();                                  // t+2
    chk("t1_start_t2", exe_start, 2'b01);
    chk("t1_addr0",    exe_addr[31:0], 32'h100);
    chk("t1_args0",    exe_args[31:0], 32'h40);
    repeat (5) step();                       // t+7
    exe_done = 2'b01;
    step();                                  // t+8, CPL
    chk("t1_cpl_early", cpl_valid, 0);
    chk("t1_start_cpl", exe_start, 2'b01);
    step();                                  // t+9
    chk("t1_cpl",       cpl_valid, 1);
    chk("t1_cpl_tag",   cpl_tag,   8'h5A);
    chk("t1_cpl_slot",  cpl_slot,  0);
    chk("t1_start_rel", exe_start, 2'b00);
    exe_done = 2'b00;
    step();                                  // t+10
    chk("t1_cpl_pulse", cpl_valid, 0);
    chk("t1_busy_rel",  busy, 1);
    step();                                  // t+11
    chk("t1_busy_end",  busy, 0);

    // ---- 2: three requests, round robin, waiting request ----
    do_reset();
    drive_req(8'h01); step();                // a+1
    drive_req(8'h02); step();                // a+2
    drive_req(8'h03); step();                // a+3
    req_valid = 1'b0;
    chk("t2_start_both", exe_start, 2'b11);
    chk("t2_addr0", exe_addr[31:0],  32'h1001);
    chk("t2_addr1", exe_addr[63:32], 32'h1002);
    chk("t2_args1", exe_args[63:32], 32'h2002);
    step(); step();                          // a+5
    exe_done = 2'b10;
    step(); step();                          // a+7
    chk("t2_cpl_tag2",  cpl_tag, 8'h02);
    chk("t2_cpl_slot1", cpl_slot, 1);
    chk("t2_cpl_v",     cpl_valid, 1);
    chk("t2_rel_a",     exe_start, 2'b01);
    exe_done = 2'b00;
    step();                                  // a+8
    chk("t2_rel_b",     exe_start, 2'b01);
    step();                                  // a+9
    chk("t2_idle",      exe_start, 2'b01);
    step();                                  // a+10
    chk("t2_tag3_slot1", exe_start, 2'b11);
    chk("t2_addr1_tag3", exe_addr[63:32], 32'h1003);
`ifdef EXEC_SCHED_STATS_EN
    chk("t2_stall", stat_stall, 6);
    chk("t2_disp",  stat_disp, 3);
    chk("t2_cplc",  stat_cpl, 1);
`endif
    exe_done = 2'b11;
    step(); step();                          // a+12
    chk("t2_cpl_tag1",  cpl_tag, 8'h01);
    chk("t2_cpl_slot0", cpl_slot, 0);
    step();                                  // a+13
    chk("t2_cpl_tag3",  cpl_tag, 8'h03);
    chk("t2_cpl_slot1b", cpl_slot, 1);
    chk("t2_cpl_v3",    cpl_valid, 1);
    exe_done = 2'b00;

    // ---- 3: simultaneous done, priority to slot 0 ----
    do_reset();
    drive_req(8'h11); step();
    drive_req(8'h22); step();
    req_valid = 1'b0;
    step();                                  // b+3
    chk("t3_start", exe_start, 2'b11);
    step();                                  // b+4
    exe_done = 2'b11;
    step();                                  // b+5
    chk("t3_no_cpl", cpl_valid, 0);
    step();                                  // b+6
    chk("t3_cpl0_v",   cpl_valid, 1);
    chk("t3_cpl0_tag", cpl_tag, 8'h11);
    chk("t3_cpl0_slot", cpl_slot, 0);
    chk("t3_start1_held", exe_start, 2'b10);
    exe_done = 2'b00;
    step();                                  // b+7
    chk("t3_cpl1_v",   cpl_valid, 1);
    chk("t3_cpl1_tag", cpl_tag, 8'h22);
    chk("t3_cpl1_slot", cpl_slot, 1);
    chk("t3_start_low", exe_start, 2'b00);
    step();
    chk("t3_cpl_end", cpl_valid, 0);

    // ---- 4: fill FIFO, backpressure, nothing lost or duplicated ----
    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk("t4_ready_fill", req_ready, 1);
      drive_req(8'h31 + 8'(i));
      step();
    end                                      // c+6
    drive_req(8'h37);
    chk("t4_full", req_ready, 0);
    exe_done = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();                                // c+7 .. c+10
      chk("t4_held", req_ready, 0);
    end
    step();                                  // c+11
    chk("t4_ready_again", req_ready, 1);
    step();
    req_valid = 1'b0;
    exe_done  = 2'b11;
    for (int i = 0; i < 300 && cpl_log.size() < 7; i++) step();
    chk("t4_cpl_count", 64'(cpl_log.size()), 7);
    foreach (cnt[i]) cnt[i] = 0;
    foreach (cpl_log[i]) begin
      if (cpl_log[i] >= 8'h31 && cpl_log[i] <= 8'h37) cnt[cpl_log[i] - 8'h31]++;
    end
    for (int i = 0; i < 7; i++) chk($sformatf("t4_once_%0d", i), 64'(cnt[i]), 1);
    exe_done = 2'b00;

    // ---- 5: stale done across re-dispatch ----
    do_reset();
    drive_req(8'h55); step();                // e+1
    drive_req(8'h66); step();                // e+2
    req_valid = 1'b0;
    chk("t5_start0", exe_start, 2'b01);
    step();                                  // e+3
    exe_done = 2'b01;
    step();                                  // e+4
    drive_req(8'h77);
    step();                                  // e+5
    req_valid = 1'b0;
    chk("t5_cpl55", cpl_tag, 8'h55);
    chk("t5_cpl55_v", cpl_valid, 1);
    step(); step(); step();                  // e+8
    chk("t5_redisp", exe_start, 2'b11);
    chk("t5_addr0", exe_addr[31:0], 32'h1077);
    step();                                  // e+9
    chk("t5_stale_a", cpl_valid, 0);
    step();                                  // e+10
    chk("t5_stale_b", cpl_valid, 0);
    chk("t5_start_cpl", exe_start, 2'b11);
    step();                                  // e+11
    chk("t5_cpl77_v", cpl_valid, 1);
    chk("t5_cpl77", cpl_tag, 8'h77);
    chk("t5_cpl77_slot", cpl_slot, 0);
    exe_done = 2'b00;

    // ---- 6: reset mid-action with queued requests ----
    do_reset();
    drive_req(8'h81); step();
    drive_req(8'h82); step();
    drive_req(8'h83); step();
    drive_req(8'h84); step();                // f+4
    req_valid = 1'b0;
    chk("t6_pre_start", exe_start, 2'b11);
    chk("t6_pre_busy",  busy, 1);
    rst = 1'b1;
    cpl_log.delete();
    step();                                  // f+5
    chk("t6_start", exe_start, 2'b00);
    chk("t6_ready", req_ready, 1);
    chk("t6_busy",  busy, 0);
    chk("t6_cpl",   cpl_valid, 0);
    rst = 1'b0;
    step(); step(); step();
    chk("t6_no_redisp", exe_start, 2'b00);
    chk("t6_no_cpl", 64'(cpl_log.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
